// File: rtl/game_pkg.sv
// Shared types and defaults for the game flow controller.
package game_pkg;

  localparam int TW_DEFAULT         = 16;
  localparam int HOLD_TICKS_DEFAULT = 150;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DEAD = 2'b10,
    ST_HOLD = 2'b11
  } state_e;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous level, followed by a registered
// rising-edge detector. All flops clear to zero in reset.
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = din;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/game_flow_controller.sv
// Game sequencing: IDLE -> RUN -> DEAD -> HOLD -> IDLE, with personal-record
// tracking of the longest survival time.
module game_flow_controller
  import game_pkg::*;
#(
  parameter int HOLD_TICKS = HOLD_TICKS_DEFAULT,
  parameter int TW         = TW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          dead_raw,
  input  logic          tick,
  input  logic [TW-1:0] elapsed,
  output logic          timer_run,
  output logic          timer_clear,
  output logic          game_active,
  output logic [TW-1:0] pr_value,
  output logic          pr_valid,
  output logic          new_pr,
  output logic [1:0]    state
);

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_TICKS - 1);

  logic start_e;
  logic dead_e;

  state_e        state_q, state_d;
  logic [7:0]    hold_cnt_q, hold_cnt_d;
  logic [TW-1:0] pr_value_q, pr_value_d;
  logic          pr_valid_q, pr_valid_d;
  logic          new_pr_q, new_pr_d;
  logic          timer_clear_q, timer_clear_d;

  sync_edge u_start_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (start),
    .rise (start_e)
  );

  sync_edge u_dead_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (dead_raw),
    .rise (dead_e)
  );

  // timer_clear is registered, so it is high during the first RUN cycle
  always_comb begin
    state_d       = state_q;
    hold_cnt_d    = hold_cnt_q;
    pr_value_d    = pr_value_q;
    pr_valid_d    = pr_valid_q;
    new_pr_d      = 1'b0;
    timer_clear_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_e) begin
          state_d       = ST_RUN;
          timer_clear_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (dead_e) begin
          state_d = ST_DEAD;
        end
      end
      ST_DEAD: begin
        state_d    = ST_HOLD;
        hold_cnt_d = 8'd0;
        if (!pr_valid_q || (elapsed > pr_value_q)) begin
          pr_value_d = elapsed;
          pr_valid_d = 1'b1;
          new_pr_d   = 1'b1;
        end
      end
      ST_HOLD: begin
        if (tick) begin
          hold_cnt_d = hold_cnt_q + 8'd1;
          if (hold_cnt_q == HOLD_LAST) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      hold_cnt_q    <= 8'd0;
      pr_value_q    <= '0;
      pr_valid_q    <= 1'b0;
      new_pr_q      <= 1'b0;
      timer_clear_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      pr_value_q    <= pr_value_d;
      pr_valid_q    <= pr_valid_d;
      new_pr_q      <= new_pr_d;
      timer_clear_q <= timer_clear_d;
    end
  end

  assign timer_run   = (state_q == ST_RUN);
  assign game_active = (state_q == ST_RUN);
  assign timer_clear = timer_clear_q;
  assign pr_value    = pr_value_q;
  assign pr_valid    = pr_valid_q;
  assign new_pr      = new_pr_q;
  assign state       = state_q;

endmodule
